gene_line_compression: RTL and testbench

- Streaming compressor. Packs one ASCII nucleotide character per cycle into 2-bit codes and assembles them into 200-bit compressed gene lines of 100 bases.
- The compressed line format is exactly the one the line decompression path consumes. Base i occupies line_data[2i+1:2i]; four bases per byte, with the lowest base in the lowest bits.
- Sits between the ASCII genome reader and the compressed-line store. Uses valid/ready handshakes on both sides.

---
 rtl/gene_line_compression_if.sv | 27 ++
 rtl/gene_line_compression.sv | 138 +++++++++++++
 tb/tb_gene_line_compression.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gene_line_compression_if.sv
// Stream bundle for the gene line compressor: ASCII bases in, packed lines out.
interface gene_line_compression_if #(
    parameter int BASES = 100,
    parameter int CNT_W = 7
);
    logic [7:0]         in_char;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [2*BASES-1:0] line_data;
    logic [CNT_W-1:0]   line_count;
    logic               line_valid;
    logic               line_ready;
    logic               err_bad_char;

    // Character source and line consumer side
    modport master (
        output in_char, in_valid, in_last, line_ready,
        input  in_ready, line_data, line_count, line_valid, err_bad_char
    );

    // Compressor side
    modport slave (
        input  in_char, in_valid, in_last, line_ready,
        output in_ready, line_data, line_count, line_valid, err_bad_char
    );
endinterface

// File: rtl/gene_line_compression.sv
// Gene line compressor: packs one ASCII base per cycle into 2-bit codes and
// emits lines of up to BASES bases, base i at line_data[2i+1:2i].
//
// state | meaning
// FILL  | accepting characters into the accumulator
// PEND  | a completed line waits in the accumulator for the output register
module gene_line_compression #(
    parameter int BASES = 100,
    parameter int CNT_W = 7
) (
    input logic                  clk,
    input logic                  rst,
    gene_line_compression_if.slave bus
);
    localparam int W = 2 * BASES;

    typedef enum logic [0:0] {FILL, PEND} state_t;

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     acc;
    logic [W-1:0]     word;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             err;
    logic [1:0]       code;
    logic             bad;
    logic             in_ready;
    logic             accept;
    logic             complete;
    logic             out_free;
    logic             out_take;

    assign in_ready = (state == FILL);
    assign accept   = bus.in_valid & in_ready;
    assign complete = accept & ((idx == CNT_W'(BASES - 1)) | bus.in_last);
    assign out_free = ~out_valid | bus.line_ready;
    assign out_take = out_valid & bus.line_ready;

    assign bus.in_ready     = in_ready;
    assign bus.line_data    = out_data;
    assign bus.line_count   = out_count;
    assign bus.line_valid   = out_valid;
    assign bus.err_bad_char = err;

    // Map an ASCII base to its 2-bit code; anything unrecognised is 00 and flagged
    always_comb begin
        code = 2'b00;
        bad  = 1'b0;
        case (bus.in_char)
            8'h41, 8'h61: code = 2'b00;
            8'h43, 8'h63: code = 2'b01;
            8'h47, 8'h67: code = 2'b10;
            8'h54, 8'h74: code = 2'b11;
            default:      bad  = 1'b1;
        endcase
    end

    // Accumulator with the incoming code inserted at idx; slots above idx forced to zero
    always_comb begin
        word = '0;
        for (int i = 0; i < BASES; i++) begin
            if (CNT_W'(i) == idx) begin
                word[2*i +: 2] = code;
            end else if (CNT_W'(i) < idx) begin
                word[2*i +: 2] = acc[2*i +: 2];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state: park in PEND when a line completes while the output is occupied
    always_comb begin
        state_next = state;
        case (state)
            FILL: if (complete && !out_free) state_next = PEND;
            PEND: if (out_take) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Accumulator, base index, output register and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept && bad) begin
                err <= 1'b1;
            end
            case (state)
                FILL: begin
                    if (out_take) begin
                        out_valid <= 1'b0;
                    end
                    if (complete) begin
                        if (out_free) begin
                            out_data  <= word;
                            out_count <= idx + CNT_W'(1);
                            out_valid <= 1'b1;
                            acc       <= '0;
                            idx       <= '0;
                        end else begin
                            // idx is kept so the held line's count is still known
                            acc <= word;
                        end
                    end else if (accept) begin
                        acc <= word;
                        idx <= idx + CNT_W'(1);
                    end
                end
                PEND: begin
                    if (out_take) begin
                        out_data  <= acc;
                        out_count <= idx + CNT_W'(1);
                        acc       <= '0;
                        idx       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gene_line_compression.sv
// Directed bench for the gene line compressor.
module tb_gene_line_compression;
    localparam int BASES = 100;
    localparam int CNT_W = 7;
    localparam int W     = 2 * BASES;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    int           n_lines = 0;
    logic [W-1:0] cap_data;
    logic [CNT_W-1:0] cap_count;

    gene_line_compression_if #(.BASES(BASES), .CNT_W(CNT_W)) bus ();

    gene_line_compression #(.BASES(BASES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Record every line handed downstream
    always @(posedge clk) begin
        if (!rst && bus.line_valid && bus.line_ready) begin
            cap_data  = bus.line_data;
            cap_count = bus.line_count;
            n_lines++;
        end
    end

    task automatic send_char(input logic [7:0] c, input logic last);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_char  = c;
        bus.in_last  = last;
        while (!bus.in_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid   = 1'b1;
        bus.in_char    = 8'h54;
        bus.in_last    = 1'b1;
        bus.line_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.line_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_line_valid: got %0b required 0", bus.line_valid);
        end
        n_cmp++;
        if (bus.line_data !== '0 || bus.line_count !== '0) begin
            n_err++;
            $display("FAIL reset_line_data: got data=%h count=%0d required 0/0", bus.line_data, bus.line_count);
        end
        n_cmp++;
        if (bus.err_bad_char !== 1'b0) begin
            n_err++;
            $display("FAIL reset_err: got %0b required 0", bus.err_bad_char);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.line_valid !== 1'b0 || n_lines != 0) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%0b line_valid=%0b lines=%0d required 1/0/0",
                     bus.in_ready, bus.line_valid, n_lines);
        end
    endtask

    task automatic test_full_line();
        logic [7:0] acgt [4];
        logic [W-1:0] exp_data;
        int drops;
        int base_lines;
        acgt = '{8'h41, 8'h43, 8'h47, 8'h54};
        exp_data = {25{8'hE4}};
        drops = 0;
        base_lines = n_lines;
        bus.line_ready = 1'b1;
        for (int i = 0; i < BASES; i++) begin
            send_char(acgt[i % 4], 1'b0);
            if (bus.in_ready !== 1'b1) drops++;
            if (i == BASES - 2) begin
                n_cmp++;
                if (bus.line_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_early_valid: got %0b required 0", bus.line_valid);
                end
            end
        end
        n_cmp++;
        if (bus.line_valid !== 1'b1 || bus.line_data !== exp_data || bus.line_count !== 7'd100) begin
            n_err++;
            $display("FAIL full_line: valid=%0b data=%h count=%0d required 1/%h/100",
                     bus.line_valid, bus.line_data, bus.line_count, exp_data);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.line_valid !== 1'b0 || n_lines != base_lines + 1) begin
            n_err++;
            $display("FAIL full_clear: valid=%0b lines=%0d required 0/%0d",
                     bus.line_valid, n_lines - base_lines, 1);
        end
        n_cmp++;
        if (drops != 0) begin
            n_err++;
            $display("FAIL full_in_ready: drops=%0d required 0", drops);
        end
    endtask

    task automatic test_short_line();
        logic [W-1:0] exp_data;
        exp_data = '0;
        exp_data[9:0] = 10'h2FF;
        bus.line_ready = 1'b1;
        send_char(8'h54, 1'b0);
        send_char(8'h54, 1'b0);
        send_char(8'h54, 1'b0);
        send_char(8'h54, 1'b0);
        send_char(8'h47, 1'b1);
        n_cmp++;
        if (bus.line_valid !== 1'b1 || bus.line_data !== exp_data || bus.line_count !== 7'd5) begin
            n_err++;
            $display("FAIL short_line: valid=%0b data=%h count=%0d required 1/%h/5",
                     bus.line_valid, bus.line_data, bus.line_count, exp_data);
        end
        send_char(8'h41, 1'b1);
        n_cmp++;
        if (bus.line_valid !== 1'b1 || bus.line_data !== '0 || bus.line_count !== 7'd1) begin
            n_err++;
            $display("FAIL short_restart: valid=%0b data=%h count=%0d required 1/0/1",
                     bus.line_valid, bus.line_data, bus.line_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_data;
        int base_lines;
        exp_data = {25{8'h55}};
        bus.line_ready = 1'b0;
        @(posedge clk);
        #1;
        base_lines = n_lines;
        for (int i = 0; i < 2 * BASES; i++) begin
            send_char(8'h43, 1'b0);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.line_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_pend: in_ready=%0b valid=%0b required 0/1", bus.in_ready, bus.line_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.line_data !== exp_data || bus.line_count !== 7'd100 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold: data=%h count=%0d in_ready=%0b required %h/100/0",
                     bus.line_data, bus.line_count, bus.in_ready, exp_data);
        end
        @(negedge clk);
        bus.line_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.line_ready = 1'b0;
        n_cmp++;
        if (bus.line_valid !== 1'b1 || bus.line_data !== exp_data || bus.line_count !== 7'd100
            || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_second: valid=%0b data=%h count=%0d in_ready=%0b required 1/%h/100/1",
                     bus.line_valid, bus.line_data, bus.line_count, bus.in_ready, exp_data);
        end
        @(negedge clk);
        bus.line_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.line_valid !== 1'b0 || n_lines != base_lines + 2 || cap_count !== 7'd100
            || cap_data !== exp_data) begin
            n_err++;
            $display("FAIL bp_drain: valid=%0b lines=%0d last_count=%0d required 0/2/100",
                     bus.line_valid, n_lines - base_lines, cap_count);
        end
    endtask

    task automatic test_bad_char();
        logic [5:0] low;
        n_cmp++;
        if (bus.err_bad_char !== 1'b0) begin
            n_err++;
            $display("FAIL bad_pre: err=%0b required 0", bus.err_bad_char);
        end
        bus.line_ready = 1'b1;
        send_char(8'h67, 1'b0);
        send_char(8'h4E, 1'b0);
        send_char(8'h74, 1'b1);
        low = bus.line_data[5:0];
        n_cmp++;
        if (bus.line_valid !== 1'b1 || low !== 6'b110010 || bus.line_data[W-1:6] !== '0
            || bus.line_count !== 7'd3) begin
            n_err++;
            $display("FAIL bad_line: valid=%0b low=%b count=%0d required 1/110010/3",
                     bus.line_valid, low, bus.line_count);
        end
        n_cmp++;
        if (bus.err_bad_char !== 1'b1) begin
            n_err++;
            $display("FAIL bad_flag: err=%0b required 1", bus.err_bad_char);
        end
        send_char(8'h41, 1'b1);
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.err_bad_char !== 1'b1 || cap_count !== 7'd1) begin
            n_err++;
            $display("FAIL bad_sticky: err=%0b last_count=%0d required 1/1", bus.err_bad_char, cap_count);
        end
    endtask

    task automatic test_reset_mid_line();
        int base_lines;
        bus.line_ready = 1'b1;
        base_lines = n_lines;
        for (int i = 0; i < 37; i++) begin
            send_char(8'h54, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (bus.err_bad_char !== 1'b0 || bus.line_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: err=%0b valid=%0b in_ready=%0b required 0/0/1",
                     bus.err_bad_char, bus.line_valid, bus.in_ready);
        end
        for (int i = 0; i < BASES; i++) begin
            send_char(8'h41, 1'b0);
        end
        n_cmp++;
        if (bus.line_valid !== 1'b1 || bus.line_data !== '0 || bus.line_count !== 7'd100) begin
            n_err++;
            $display("FAIL mid_line: valid=%0b data=%h count=%0d required 1/0/100",
                     bus.line_valid, bus.line_data, bus.line_count);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (n_lines != base_lines + 1) begin
            n_err++;
            $display("FAIL mid_line_count: lines=%0d required 1", n_lines - base_lines);
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_char    = 8'h00;
        bus.in_last    = 1'b0;
        bus.line_ready = 1'b1;
        test_reset();
        test_full_line();
        test_short_line();
        test_backpressure();
        test_bad_char();
        test_reset_mid_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
